idma_axi_256b_slv_sram: RTL

//  AXI3-style 256b slave responder: far end of the iDMA rd/wr channel master ports. Terminates AR/R and AW/W/B

---
 rtl/idma_axi_256b_slv_sram_if.sv | 76 +++++++
 rtl/idma_axi_256b_slv_sram.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/idma_axi_256b_slv_sram_if.sv
// ---------------------------------------------------------------------------
// idma_axi_256b_slv_sram_if
//  AXI3-style bundle between an iDMA channel master and the 256b SRAM slave.
//  Carries the AR/R read channels and the AW/W/B write channels.
//  modport master : drives AR/AW/W payloads and rready/bready
//  modport slave  : drives arready/awready/wready and the R/B responses
// ---------------------------------------------------------------------------
interface idma_axi_256b_slv_sram_if #(
  parameter int AXI_DATA_WID = 256,
  parameter int AXI_ADDR_WID = 32,
  parameter int AXI_IDW      = 4,
  parameter int AXI_LENW     = 4,
  parameter int AXI_STRBW    = 32
);
  // read address
  logic                    arvalid;
  logic                    arready;
  logic [AXI_IDW-1:0]      arid;
  logic [AXI_ADDR_WID-1:0] araddr;
  logic [AXI_LENW-1:0]     arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  // read data
  logic                    rvalid;
  logic                    rready;
  logic [AXI_IDW-1:0]      rid;
  logic [AXI_DATA_WID-1:0] rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  // write address
  logic                    awvalid;
  logic                    awready;
  logic [AXI_IDW-1:0]      awid;
  logic [AXI_ADDR_WID-1:0] awaddr;
  logic [AXI_LENW-1:0]     awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  // write data
  logic                    wvalid;
  logic                    wready;
  logic [AXI_IDW-1:0]      wid;
  logic [AXI_DATA_WID-1:0] wdata;
  logic [AXI_STRBW-1:0]    wstrb;
  logic                    wlast;
  // write response
  logic                    bvalid;
  logic                    bready;
  logic [AXI_IDW-1:0]      bid;
  logic [1:0]              bresp;

  modport master (
    output arvalid, arid, araddr, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast,
    output rready,
    output awvalid, awid, awaddr, awlen, awsize, awburst,
    input  awready,
    output wvalid, wid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready
  );

  modport slave (
    input  arvalid, arid, araddr, arlen, arsize, arburst,
    output arready,
    output rvalid, rid, rdata, rresp, rlast,
    input  rready,
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    output awready,
    input  wvalid, wid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready
  );
endinterface

// File: rtl/idma_axi_256b_slv_sram.sv
// ---------------------------------------------------------------------------
// idma_axi_256b_slv_sram
//  AXI3-style 256b slave responder terminating iDMA read/write bursts onto a
//  single-port SRAM with 1-cycle read latency. One burst is in service at a
//  time; reads and writes are arbitrated per burst (alternating on collision).
//
//  Ports
//   aclk, aresetn : clock, asynchronous active-low reset
//   axi           : AR/R/AW/W/B bundle (slave modport)
//   mem_cs/mem_we : SRAM select / write enable
//   mem_addr      : SRAM word address (addr[MEM_AW+4:5])
//   mem_wdata     : SRAM write data, mem_be byte enables
//   mem_rdata     : SRAM read data, valid the cycle after a read select
// ---------------------------------------------------------------------------
module idma_axi_256b_slv_sram #(
  parameter int AXI_DATA_WID = 256,
  parameter int AXI_ADDR_WID = 32,
  parameter int AXI_IDW      = 4,
  parameter int AXI_LENW     = 4,
  parameter int AXI_STRBW    = 32,
  parameter int MEM_AW       = 10
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  idma_axi_256b_slv_sram_if.slave axi,
  output logic                    mem_cs,
  output logic                    mem_we,
  output logic [MEM_AW-1:0]       mem_addr,
  output logic [AXI_DATA_WID-1:0] mem_wdata,
  output logic [AXI_STRBW-1:0]    mem_be,
  input  logic [AXI_DATA_WID-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_BRSP} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [2:0] SIZE_32B    = 3'b101;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // Address-phase legality: out-of-window address beats a bad size/burst.
  function automatic logic [1:0] a_check(input logic [AXI_ADDR_WID-1:0] addr,
                                         input logic [2:0] size,
                                         input logic [1:0] burst);
    logic [1:0] resp;
    resp = RESP_OKAY;
    if (addr[AXI_ADDR_WID-1:MEM_AW+5] != '0)
      resp = RESP_DECERR;
    else if (size != SIZE_32B || burst != BURST_INCR)
      resp = RESP_SLVERR;
    return resp;
  endfunction

  state_t                  state_q, state_d;
  logic                    last_wr_q;      // 1: last grant went to the write side
  logic [AXI_IDW-1:0]      id_q;
  logic [1:0]              resp_q;
  logic [AXI_LENW-1:0]     len_q;
  logic [MEM_AW-1:0]       addr_q;

  // read side
  logic [AXI_LENW-1:0]     issue_left_q;   // SRAM reads still to issue
  logic [AXI_LENW-1:0]     beats_left_q;   // R beats after the current head
  logic                    pend_q;         // a read (or zero beat) lands this cycle
  logic [AXI_DATA_WID-1:0] fifo_q [2];
  logic                    fifo_wr_q, fifo_rd_q;
  logic [1:0]              cnt_q;

  // write side
  logic [AXI_LENW:0]       wbeat_q;        // 0-based index of the next W beat
  logic                    wid_bad_q;

  logic                    in_idle, grant_rd, grant_wr;
  logic                    ar_hs, aw_hs, r_pop, w_hs;
  logic                    rd_issue, w_write, push;
  logic [1:0]              ar_resp_c, aw_resp_c, w_last_resp;
  logic [1:0]              occ_after;

  logic                    unused_addr_bits;
  assign unused_addr_bits = ^{axi.araddr[4:0], axi.awaddr[4:0]};

  // ---- arbitration / address handshake ----
  assign in_idle  = (state_q == S_IDLE) && aresetn;
  assign grant_rd = axi.arvalid && (!axi.awvalid || last_wr_q);
  assign grant_wr = axi.awvalid && (!axi.arvalid || !last_wr_q);

  assign axi.arready = in_idle && grant_rd;
  assign axi.awready = in_idle && grant_wr;
  assign ar_hs       = axi.arvalid && axi.arready;
  assign aw_hs       = axi.awvalid && axi.awready;
  assign ar_resp_c   = a_check(axi.araddr, axi.arsize, axi.arburst);
  assign aw_resp_c   = a_check(axi.awaddr, axi.awsize, axi.awburst);

  // ---- read issue and 2-entry R skid FIFO ----
  assign axi.rvalid = (cnt_q != 2'd0);
  assign r_pop      = axi.rvalid && axi.rready;
  assign axi.rdata  = fifo_q[fifo_rd_q];
  assign axi.rid    = id_q;
  assign axi.rresp  = resp_q;
  assign axi.rlast  = axi.rvalid && (beats_left_q == '0);

  // Entries held plus the one landing now, minus the one leaving now, must
  // leave a free slot for whatever a read issued this cycle returns next cycle.
  assign occ_after = cnt_q + {1'b0, pend_q} - {1'b0, r_pop};
  assign rd_issue  = (state_q == S_RD) && (issue_left_q != '0) && (occ_after < 2'd2);
  assign push      = pend_q;

  // ---- write data ----
  assign axi.wready = (state_q == S_WR);
  assign w_hs       = axi.wvalid && axi.wready;
  assign w_write    = w_hs && (wbeat_q <= {1'b0, len_q}) && (resp_q == RESP_OKAY);

  always_comb begin
    w_last_resp = RESP_OKAY;
    if (resp_q != RESP_OKAY)
      w_last_resp = resp_q;
    else if ((wbeat_q != {1'b0, len_q}) || wid_bad_q || (axi.wid != id_q))
      w_last_resp = RESP_SLVERR;
  end

  assign axi.bvalid = (state_q == S_BRSP);
  assign axi.bid    = id_q;
  assign axi.bresp  = resp_q;

  // ---- SRAM port ----
  // The first read of a burst is issued in the AR handshake cycle itself so
  // the first R beat appears two cycles after the handshake.
  assign mem_cs    = (ar_hs && (ar_resp_c == RESP_OKAY)) ||
                     (rd_issue && (resp_q == RESP_OKAY)) || w_write;
  assign mem_we    = w_write;
  assign mem_addr  = in_idle ? axi.araddr[MEM_AW+4:5] : addr_q;
  assign mem_wdata = axi.wdata;
  assign mem_be    = w_write ? axi.wstrb : '0;

  // ---- FSM next state ----
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (ar_hs)      state_d = S_RD;
        else if (aw_hs) state_d = S_WR;
      end
      S_RD:   if (r_pop && (beats_left_q == '0)) state_d = S_IDLE;
      S_WR:   if (w_hs && axi.wlast)             state_d = S_BRSP;
      S_BRSP: if (axi.bready)                    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // ---- burst context ----
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      last_wr_q    <= 1'b0;
      id_q         <= '0;
      resp_q       <= RESP_OKAY;
      len_q        <= '0;
      addr_q       <= '0;
      issue_left_q <= '0;
      beats_left_q <= '0;
      wbeat_q      <= '0;
      wid_bad_q    <= 1'b0;
    end else begin
      if (ar_hs) begin
        last_wr_q    <= 1'b0;
        id_q         <= axi.arid;
        resp_q       <= ar_resp_c;
        len_q        <= axi.arlen;
        addr_q       <= axi.araddr[MEM_AW+4:5] + 1'b1;
        issue_left_q <= axi.arlen;
        beats_left_q <= axi.arlen;
      end else if (aw_hs) begin
        last_wr_q <= 1'b1;
        id_q      <= axi.awid;
        resp_q    <= aw_resp_c;
        len_q     <= axi.awlen;
        addr_q    <= axi.awaddr[MEM_AW+4:5];
        wbeat_q   <= '0;
        wid_bad_q <= 1'b0;
      end else begin
        if (rd_issue) begin
          addr_q       <= addr_q + 1'b1;
          issue_left_q <= issue_left_q - 1'b1;
        end
        if (r_pop)
          beats_left_q <= beats_left_q - 1'b1;
        if (w_hs) begin
          if (w_write)        addr_q    <= addr_q + 1'b1;
          if (wbeat_q != '1)  wbeat_q   <= wbeat_q + 1'b1;
          if (axi.wid != id_q) wid_bad_q <= 1'b1;
          if (axi.wlast)      resp_q    <= w_last_resp;
        end
      end
    end
  end

  // ---- read return: SRAM data (or zeros for an errored burst) into FIFO ----
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pend_q    <= 1'b0;
      cnt_q     <= 2'd0;
      fifo_wr_q <= 1'b0;
      fifo_rd_q <= 1'b0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else begin
      pend_q <= ar_hs || rd_issue;
      if (push) begin
        fifo_q[fifo_wr_q] <= (resp_q == RESP_OKAY) ? mem_rdata : '0;
        fifo_wr_q         <= ~fifo_wr_q;
      end
      if (r_pop)
        fifo_rd_q <= ~fifo_rd_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, r_pop};
    end
  end

endmodule
